// File: rtl/tt_bridge_pkg.sv
// tt_bridge_pkg: shared states, opcodes and command-byte layout for the host bridge
package tt_bridge_pkg;
  typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_MREQ, S_RWAIT, S_RSP} state_t;
  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_CTRL = 2'b11;
  localparam int CMD_OP_HI = 7;
  localparam int CMD_OP_LO = 6;
  localparam int CMD_LEN_HI = 3;
  localparam int CMD_LEN_LO = 0;
  localparam int CMD_FLAG = 0;
  function automatic logic [1:0] cmd_op(input logic [7:0] cmd);
    return cmd[CMD_OP_HI:CMD_OP_LO];
  endfunction
  function automatic logic [3:0] cmd_len(input logic [7:0] cmd);
    return cmd[CMD_LEN_HI:CMD_LEN_LO];
  endfunction
endpackage

// File: rtl/tt_bridge_shreg.sv
// tt_bridge_shreg: byte-wide shift register with parallel load
module tt_bridge_shreg #(
  parameter int BYTES = 4,
  parameter bit MSB_IN = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [8*BYTES-1:0] load_data,
  input  logic [7:0]         in_byte,
  output logic [8*BYTES-1:0] data_q
);
  localparam int W = 8 * BYTES;
  logic [W-1:0] data_d;
  // load wins over shift; MSB_IN shifts right with the new byte entering at the top
  always_comb begin
    data_d = load ? load_data
           : shift ? (MSB_IN ? W'({in_byte, data_q} >> 8) : W'({data_q, in_byte}))
           : data_q;
  end
  // register the word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else data_q <= data_d;
  end
endmodule

// File: rtl/tt_host_bridge.sv
// tt_host_bridge: byte-serial host to memory-bus bridge with CPU halt control
module tt_host_bridge
  import tt_bridge_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter bit HALT_AT_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        host_data,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_halt,
  output logic              busy,
  output logic              err
);
  localparam int AB = ADDR_W / 8;
  localparam int DB = DATA_W / 8;
  localparam int MB = AB > DB ? AB : DB;
  localparam int CW = $clog2(MB + 1);
  localparam int TW = $clog2(MEM_TIMEOUT + 2);
  state_t state_q, state_d;
  logic [3:0] words_q, words_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic we_q, we_d, halt_q, halt_d, err_q, err_d;
  logic a_ld, a_sh, w_sh, r_ld, r_sh, word_done, tmo_hit;
  logic [DATA_W-1:0] rdata_q;
  logic unused_r;
  tt_bridge_shreg #(.BYTES(AB), .MSB_IN(1'b0)) u_addr (
    .clk(clk), .rst(rst), .load(a_ld), .shift(a_sh),
    .load_data(mem_addr + ADDR_W'(DB)), .in_byte(host_data), .data_q(mem_addr)
  );
  tt_bridge_shreg #(.BYTES(DB), .MSB_IN(1'b1)) u_wdata (
    .clk(clk), .rst(rst), .load(1'b0), .shift(w_sh),
    .load_data('0), .in_byte(host_data), .data_q(mem_wdata)
  );
  tt_bridge_shreg #(.BYTES(DB), .MSB_IN(1'b1)) u_rdata (
    .clk(clk), .rst(rst), .load(r_ld), .shift(r_sh),
    .load_data(mem_rdata), .in_byte(8'h00), .data_q(rdata_q)
  );
  assign unused_r = ^rdata_q;
  assign host_ready = state_q == S_CMD || state_q == S_ADDR || state_q == S_WDATA;
  assign busy = state_q != S_CMD;
  assign mem_req = state_q == S_MREQ;
  assign rsp_valid = state_q == S_RSP;
  assign rsp_data = rdata_q[7:0];
  assign mem_we = we_q;
  assign cpu_halt = halt_q;
  assign err = err_q;
  // next-state and datapath strobes; word completion is handled once at the end
  always_comb begin
    state_d = state_q;
    words_d = words_q;
    cnt_d = cnt_q;
    tmo_d = tmo_q + TW'(1);
    we_d = we_q;
    halt_d = halt_q;
    err_d = err_q;
    a_ld = 1'b0;
    a_sh = 1'b0;
    w_sh = 1'b0;
    r_ld = 1'b0;
    r_sh = 1'b0;
    word_done = 1'b0;
    tmo_hit = MEM_TIMEOUT != 0 && tmo_q == TW'(MEM_TIMEOUT - 1);
    case (state_q)
      S_CMD: if (host_valid)
        case (cmd_op(host_data))
          OP_NOP: err_d = host_data[CMD_FLAG] ? 1'b0 : err_q;
          OP_CTRL: halt_d = host_data[CMD_FLAG];
          OP_READ, OP_WRITE: begin
            we_d = cmd_op(host_data) == OP_WRITE;
            words_d = cmd_len(host_data);
            cnt_d = '0;
            state_d = S_ADDR;
          end
        endcase
      S_ADDR: if (host_valid) begin
        a_sh = 1'b1;
        cnt_d = cnt_q == CW'(AB - 1) ? '0 : cnt_q + CW'(1);
        tmo_d = '0;
        state_d = cnt_q != CW'(AB - 1) ? S_ADDR : we_q ? S_WDATA : S_MREQ;
      end
      S_WDATA: if (host_valid) begin
        w_sh = 1'b1;
        cnt_d = cnt_q == CW'(DB - 1) ? '0 : cnt_q + CW'(1);
        tmo_d = '0;
        state_d = cnt_q == CW'(DB - 1) ? S_MREQ : S_WDATA;
      end
      S_MREQ: if (mem_gnt) begin
        word_done = we_q;
        r_ld = !we_q && mem_rvalid;
        cnt_d = '0;
        tmo_d = '0;
        state_d = we_q ? state_q : mem_rvalid ? S_RSP : S_RWAIT;
      end else if (tmo_hit) begin
        err_d = 1'b1;
        state_d = S_CMD;
      end
      S_RWAIT: if (mem_rvalid) begin
        r_ld = 1'b1;
        cnt_d = '0;
        state_d = S_RSP;
      end else if (tmo_hit) begin
        err_d = 1'b1;
        state_d = S_CMD;
      end
      S_RSP: if (rsp_ready) begin
        r_sh = 1'b1;
        cnt_d = cnt_q + CW'(1);
        word_done = cnt_q == CW'(DB - 1);
      end
      default: state_d = S_CMD;
    endcase
    if (word_done) begin
      a_ld = 1'b1;
      cnt_d = '0;
      tmo_d = '0;
      words_d = words_q - 4'd1;
      state_d = words_q == 4'd0 ? S_CMD : we_q ? S_WDATA : S_MREQ;
    end
  end
  // control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CMD;
      words_q <= '0;
      cnt_q <= '0;
      tmo_q <= '0;
      we_q <= 1'b0;
      halt_q <= HALT_AT_RESET;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      we_q <= we_d;
      halt_q <= halt_d;
      err_q <= err_d;
    end
  end
endmodule
